rx_cmd_sequencer: RTL and testbench
===================================

# rx_cmd_sequencer

Controller that drains the receive FIFO (rx_fifo) and assembles GPU command packets from its byte stream. It owns the FIFO read side (r_enable, r_data, empty) and presents each complete command (opcode plus 0/2/4/6 payload bytes) to the GPU core through a valid/ready handshake. It discards sync bytes and aborts commands that stall mid-payload.

## Interface
- TIMEOUT, default 64: consecutive empty-FIFO cycles tolerated mid-payload before abort; must be ≥1.
- SYNC_BYTE, default 8'hFF: opcode value discarded as idle/sync filler.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  when low, no new opcode is accepted; a command already in progress completes.
- fifo_empty  in  1  rx_fifo empty flag.
- fifo_r_data  in  8  rx_fifo head byte; valid whenever fifo_empty=0 (first-word fall-through).
- fifo_r_enable  out  1  pops the head byte on this clock edge.
- cmd_valid  out  1  command held on cmd_opcode/cmd_payload is valid.
- cmd_ready  in  1  GPU core accepts the command.
- cmd_opcode  out  8  opcode of the held command.
- cmd_payload  out  48  payload; byte k in bits [8k+7:8k]; bytes beyond length are zero.
- busy  out  1  high whenever state ≠ IDLE.
- err_timeout  out  1  one-cycle pulse on payload-stall abort.

## Operation
- Length decode from opcode[7:6]: 00→0, 01→2, 10→4, 11→6 payload bytes.
- States: IDLE, PAYLOAD, ISSUE.
- IDLE: fifo_r_enable = en & ~fifo_empty. On a pop: if byte == SYNC_BYTE, discard and stay IDLE; else latch cmd_opcode, clear cmd_payload and byte index, go to PAYLOAD (length>0) or ISSUE (length 0).
- PAYLOAD: fifo_r_enable = ~fifo_empty (en ignored). Each pop writes fifo_r_data to payload byte[index], index+1. Pop of the last byte → ISSUE. SYNC_BYTE is ordinary data here.
- Stall counter: cleared on entry to PAYLOAD and on every pop; increments each PAYLOAD cycle with fifo_empty=1. On the cycle it would reach TIMEOUT: err_timeout=1 for that one cycle, payload/opcode cleared, state → IDLE.
- ISSUE: cmd_valid=1, fifo_r_enable=0, outputs stable. cmd_valid&cmd_ready → IDLE, cmd_valid low next cycle; outputs hold until next opcode latched.
- fifo_r_enable is never asserted while fifo_empty=1.
- Reset (any time, including mid-command): state IDLE, all outputs 0, cmd_opcode/cmd_payload 0, counters 0; partial command lost, no err_timeout.

## Timing
- Opcode popped at edge N (length 0) → cmd_valid high in cycle N+1.
- Length L, FIFO never empty: opcode pop edge N, payload pops N+1..N+L, cmd_valid from cycle N+L+1.
- After handshake edge M, earliest next opcode pop is edge M+1 (one idle cycle minimum between commands).
- Abort: the TIMEOUT-th consecutive empty PAYLOAD cycle carries err_timeout; IDLE from the next cycle. A pop in that same cycle is impossible (FIFO empty).
- cmd_ready ignored outside ISSUE.

## Structure
- Package rx_cmd_pkg: state enum (IDLE, PAYLOAD, ISSUE), MAX_PAYLOAD=6 constant, function payload_len(opcode) returning 0–6.
- Stall counter instantiated as flex_counter (clear, count_enable, rollover at TIMEOUT); remainder in one module.

## Test plan
- Reset mid-PAYLOAD after 3 bytes of an 8'h80 command -> all outputs 0, next FIFO bytes 8'h01 then 8'h02 handled from IDLE.
- FIFO holds 8'h41, 8'hAA, 8'hBB, cmd_ready=1 -> cmd_valid 3 cycles after opcode pop, cmd_opcode=8'h41, cmd_payload=48'h0000_0000_BBAA, one-cycle pulse.
- FIFO holds 8'hFF, 8'hFF, 8'h05 -> two sync bytes discarded, cmd_opcode=8'h05, payload 0, no err.
- Opcode 8'hC3 then 2 bytes, FIFO empty for TIMEOUT cycles -> err_timeout single pulse, no cmd_valid, busy low next cycle, following 8'h00 issued normally.
- cmd_ready low 10 cycles on 8'h00 command -> cmd_valid/cmd_opcode held, fifo_r_enable 0 throughout despite non-empty FIFO.
- en=0 with FIFO non-empty -> no pops; en dropped mid-PAYLOAD of 8'h80 -> command completes with 4 bytes.

Source files
------------

// File: rtl/rx_cmd_pkg.sv
// rtl/rx_cmd_pkg.sv - shared state type, payload size and length decode for rx_cmd_sequencer
//
// Contents:
//   state_t      : sequencer states IDLE / PAYLOAD / ISSUE
//   MAX_PAYLOAD  : largest payload in bytes
//   payload_len  : payload byte count carried by an opcode (0, 2, 4 or 6)

package rx_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  localparam int MAX_PAYLOAD = 6;

  // opcode[7:6] selects 0/2/4/6 bytes, i.e. twice the field value.
  function automatic logic [2:0] payload_len(input logic [7:0] opcode);
    return {opcode[7:6], 1'b0};
  endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter with clear and a rollover strobe at a fixed terminal value
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous return to zero (wins over counting)
//   count_enable  : advance by one this cycle
//   rollover      : combinational, high on the enabled cycle that would reach ROLLOVER;
//                   the count wraps to zero on that edge

module flex_counter #(
  parameter int ROLLOVER = 64,
  parameter int WIDTH    = $clog2(ROLLOVER + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_enable,
  output logic rollover
);

  logic [WIDTH-1:0] count;

  assign rollover = count_enable && (count == WIDTH'(ROLLOVER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || rollover) begin
      count <= '0;
    end else if (count_enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_cmd_sequencer.sv
// rtl/rx_cmd_sequencer.sv - drains rx_fifo and assembles opcode+payload commands for the GPU core
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : gate on accepting new opcodes (a command in flight always completes)
//   fifo_empty      : rx_fifo empty flag
//   fifo_r_data     : rx_fifo head byte (first-word fall-through)
//   fifo_r_enable   : pop head byte on this edge
//   cmd_valid       : command on cmd_opcode/cmd_payload is valid
//   cmd_ready       : GPU core accepts command
//   cmd_opcode      : opcode of held command
//   cmd_payload     : payload, byte k in bits [8k+7:8k], unused bytes zero
//   busy            : sequencer not idle
//   err_timeout     : one-cycle pulse when a stalled payload is abandoned

module rx_cmd_sequencer
  import rx_cmd_pkg::*;
#(
  parameter int         TIMEOUT   = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_r_data,
  output logic        fifo_r_enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [47:0] cmd_payload,
  output logic        busy,
  output logic        err_timeout
);

  state_t      state, state_n;
  logic [7:0]  opcode_n;
  logic [47:0] payload_n;
  logic [2:0]  idx, idx_n;
  logic        stall_clear, stall_en, stall_hit;

  // Stall counter only runs while waiting on payload bytes; any pop or
  // leaving PAYLOAD restarts the count.
  assign stall_en    = (state == PAYLOAD) && fifo_empty;
  assign stall_clear = (state != PAYLOAD) || fifo_r_enable;

  flex_counter #(
    .ROLLOVER(TIMEOUT)
  ) u_stall (
    .clk         (clk),
    .rst         (rst),
    .clear       (stall_clear),
    .count_enable(stall_en),
    .rollover    (stall_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_opcode  <= '0;
      cmd_payload <= '0;
      idx         <= '0;
    end else begin
      state       <= state_n;
      cmd_opcode  <= opcode_n;
      cmd_payload <= payload_n;
      idx         <= idx_n;
    end
  end

  always_comb begin
    state_n       = state;
    opcode_n      = cmd_opcode;
    payload_n     = cmd_payload;
    idx_n         = idx;
    fifo_r_enable = 1'b0;
    err_timeout   = 1'b0;
    unique case (state)
      IDLE: begin
        // Held low during reset so no byte is lost while the block is cleared.
        fifo_r_enable = en && !fifo_empty && !rst;
        if (fifo_r_enable && (fifo_r_data != SYNC_BYTE)) begin
          opcode_n  = fifo_r_data;
          payload_n = '0;
          idx_n     = '0;
          state_n   = (payload_len(fifo_r_data) == 3'd0) ? ISSUE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        fifo_r_enable = !fifo_empty && !rst;
        if (fifo_r_enable) begin
          payload_n[{idx, 3'b000} +: 8] = fifo_r_data;
          idx_n = idx + 3'd1;
          if (idx_n == payload_len(cmd_opcode)) begin
            state_n = ISSUE;
          end
        end else if (stall_hit) begin
          err_timeout = 1'b1;
          opcode_n    = '0;
          payload_n   = '0;
          idx_n       = '0;
          state_n     = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd_valid = (state == ISSUE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// tb/tb_rx_cmd_sequencer.sv - self-checking bench for rx_cmd_sequencer with a queue-based FIFO and command model

module tb_rx_cmd_sequencer;

  localparam int         TIMEOUT = 8;
  localparam logic [7:0] SYNC    = 8'hFF;

  typedef struct packed {
    logic [7:0]  op;
    logic [47:0] pl;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_r_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        fifo_r_enable, cmd_valid, busy, err_timeout;
  logic [7:0]  cmd_opcode;
  logic [47:0] cmd_payload;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] src_q[$];
  cmd_t       got_q[$];
  cmd_t       exp_q[$];
  int         feed_pct = 0;
  int         empty_run = 0;
  int         err_seen = 0;

  logic        s_ren, s_valid, s_busy, s_err, s_rdy;
  logic [7:0]  s_op;
  logic [47:0] s_pl;

  rx_cmd_sequencer #(
    .TIMEOUT  (TIMEOUT),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_r_enable(fifo_r_enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_payload  (cmd_payload),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // One clock: present FIFO head, sample outputs at the falling edge,
  // then apply pop / handshake / feed after the rising edge.
  task automatic tick();
    cmd_t c;
    fifo_empty = (fifo_q.size() == 0);
    if (fifo_empty) fifo_r_data = 8'h00;
    else            fifo_r_data = fifo_q[0];
    @(negedge clk);
    s_ren = fifo_r_enable; s_valid = cmd_valid; s_busy = busy; s_err = err_timeout;
    s_op = cmd_opcode; s_pl = cmd_payload; s_rdy = cmd_ready;
    if (fifo_empty) begin
      checks++;
      if (s_ren !== 1'b0) begin errors++; $display("FAIL pop_while_empty got %b want 0", s_ren); end
    end
    @(posedge clk);
    #1;
    if (s_ren && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (s_valid && s_rdy) begin
      c.op = s_op; c.pl = s_pl;
      got_q.push_back(c);
    end
    if (s_err) err_seen++;
    if (fifo_q.size() == 0) empty_run++; else empty_run = 0;
    if (src_q.size() > 0 && ((int'($urandom_range(99)) < feed_pct) || empty_run >= 3))
      fifo_q.push_back(src_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; fifo_empty = 1'b0; fifo_r_data = 8'h80;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (fifo_r_enable !== 1'b0) begin errors++; $display("FAIL rst_ren got %b want 0", fifo_r_enable); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", cmd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_timeout); end
    checks++; if (cmd_opcode !== 8'h00) begin errors++; $display("FAIL rst_op got %h want 00", cmd_opcode); end
    checks++; if (cmd_payload !== 48'h0) begin errors++; $display("FAIL rst_pl got %h want 0", cmd_payload); end
    @(posedge clk); #1; rst = 1'b0;
    // Reset in the middle of an 8'h80 payload after three bytes.
    fifo_q = {8'h80, 8'h11, 8'h22, 8'h33};
    cmd_ready = 1'b1;
    repeat (4) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    checks++; if (cmd_opcode !== 8'h80) begin errors++; $display("FAIL mid_op got %h want 80", cmd_opcode); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    checks++; if (cmd_opcode !== 8'h00) begin errors++; $display("FAIL arst_op got %h want 00", cmd_opcode); end
    checks++; if (cmd_payload !== 48'h0) begin errors++; $display("FAIL arst_pl got %h want 0", cmd_payload); end
    checks++; if (fifo_r_enable !== 1'b0) begin errors++; $display("FAIL arst_ren got %b want 0", fifo_r_enable); end
    @(posedge clk); #1; rst = 1'b0;
    got_q.delete(); err_seen = 0;
    fifo_q = {8'h01, 8'h02};
    for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL post_rst_count got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== {8'h01, 48'h0}) begin errors++; $display("FAIL post_rst_cmd0 got %h want 01", got_q[0]); end
      checks++; if (got_q[1] !== {8'h02, 48'h0}) begin errors++; $display("FAIL post_rst_cmd1 got %h want 02", got_q[1]); end
    end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL post_rst_err got %0d want 0", err_seen); end
  endtask

  task automatic test_basic();
    fifo_q = {8'h41, 8'hAA, 8'hBB};
    cmd_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      case (i)
        0: begin checks++; if (s_ren !== 1'b1) begin errors++; $display("FAIL basic_pop got %b want 1", s_ren); end end
        1, 2: begin checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid c%0d got %b want 0", i, s_valid); end end
        3: begin
          checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", s_valid); end
          checks++; if (s_op !== 8'h41) begin errors++; $display("FAIL basic_op got %h want 41", s_op); end
          checks++; if (s_pl !== 48'h0000_0000_BBAA) begin errors++; $display("FAIL basic_pl got %h want BBAA", s_pl); end
        end
        default: begin
          checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", s_valid); end
          checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", s_busy); end
        end
      endcase
    end
  endtask

  task automatic test_sync();
    fifo_q = {8'hFF, 8'hFF, 8'h05};
    err_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      case (i)
        1: begin checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL sync_busy got %b want 0", s_busy); end end
        2: begin checks++; if (s_ren !== 1'b1) begin errors++; $display("FAIL sync_pop got %b want 1", s_ren); end end
        3: begin
          checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL sync_valid got %b want 1", s_valid); end
          checks++; if (s_op !== 8'h05) begin errors++; $display("FAIL sync_op got %h want 05", s_op); end
          checks++; if (s_pl !== 48'h0) begin errors++; $display("FAIL sync_pl got %h want 0", s_pl); end
        end
        default: ;
      endcase
    end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL sync_err got %0d want 0", err_seen); end
  endtask

  task automatic test_timeout();
    fifo_q = {8'hC3, 8'h01, 8'h02};
    err_seen = 0; got_q.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL to_valid c%0d got %b want 0", i, s_valid); end
      if (i == 3 + TIMEOUT - 2) begin
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", s_err); end
      end
      if (i == 3 + TIMEOUT - 1) begin
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", s_err); end
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL to_busy got %b want 1", s_busy); end
      end
      if (i == 3 + TIMEOUT) begin
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL to_len got %b want 0", s_err); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL to_idle got %b want 0", s_busy); end
        checks++; if (s_op !== 8'h00) begin errors++; $display("FAIL to_op_clr got %h want 00", s_op); end
        checks++; if (s_pl !== 48'h0) begin errors++; $display("FAIL to_pl_clr got %h want 0", s_pl); end
      end
    end
    checks++; if (err_seen != 1) begin errors++; $display("FAIL to_count got %0d want 1", err_seen); end
    fifo_q.push_back(8'h00);
    for (int i = 0; i < 10 && got_q.size() < 1; i++) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL to_next_count got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== {8'h00, 48'h0}) begin errors++; $display("FAIL to_next_cmd got %h want 0", got_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    fifo_q = {8'h00, 8'h11, 8'h22};
    cmd_ready = 1'b0; got_q.delete();
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (s_ren !== 1'b1) begin errors++; $display("FAIL bp_pop got %b want 1", s_ren); end
      end else begin
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", i, s_valid); end
        checks++; if (s_op !== 8'h00) begin errors++; $display("FAIL bp_op c%0d got %h want 00", i, s_op); end
        checks++; if (s_ren !== 1'b0) begin errors++; $display("FAIL bp_ren c%0d got %b want 0", i, s_ren); end
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL bp_busy c%0d got %b want 1", i, s_busy); end
      end
    end
    cmd_ready = 1'b1;
    tick();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_hs got %b want 1", s_valid); end
    tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", s_valid); end
    checks++; if (s_ren !== 1'b1) begin errors++; $display("FAIL bp_next_pop got %b want 1", s_ren); end
    repeat (5) tick();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_q.size()); end
    else begin
      checks++; if (got_q[1].op !== 8'h11 || got_q[2].op !== 8'h22) begin
        errors++; $display("FAIL bp_order got %h %h want 11 22", got_q[1].op, got_q[2].op);
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b0; cmd_ready = 1'b1; got_q.delete();
    fifo_q = {8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_ren !== 1'b0) begin errors++; $display("FAIL en_hold c%0d got %b want 0", i, s_ren); end
    end
    en = 1'b1;
    tick();
    checks++; if (s_ren !== 1'b1) begin errors++; $display("FAIL en_pop got %b want 1", s_ren); end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (s_ren !== 1'b1) begin errors++; $display("FAIL en_payload c%0d got %b want 1", i, s_ren); end
    end
    tick();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL en_valid got %b want 1", s_valid); end
    checks++; if (s_op !== 8'h80) begin errors++; $display("FAIL en_op got %h want 80", s_op); end
    checks++; if (s_pl !== 48'h0000_0403_0201) begin errors++; $display("FAIL en_pl got %h want 04030201", s_pl); end
    fifo_q.push_back(8'h05);
    repeat (2) begin
      tick();
      checks++; if (s_ren !== 1'b0) begin errors++; $display("FAIL en_gate got %b want 0", s_ren); end
    end
    en = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_random();
    cmd_t c;
    logic [7:0] op;
    int len;
    got_q.delete(); exp_q.delete(); src_q.delete(); err_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(4) == 0) src_q.push_back(SYNC);
      op = 8'($urandom_range(254));
      len = int'(op[7:6]) * 2;
      c.op = op; c.pl = '0;
      src_q.push_back(op);
      for (int k = 0; k < len; k++) begin
        c.pl[8*k +: 8] = 8'($urandom);
        src_q.push_back(c.pl[8*k +: 8]);
      end
      exp_q.push_back(c);
    end
    feed_pct = 60;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      en = ($urandom_range(9) != 0);
      cmd_ready = ($urandom_range(2) != 0);
      tick();
      if (got_q.size() == exp_q.size() && src_q.size() == 0 && fifo_q.size() == 0) break;
    end
    feed_pct = 0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n] !== exp_q[n]) begin
        errors++; $display("FAIL rnd_cmd%0d got %h/%h want %h/%h", n, got_q[n].op, got_q[n].pl, exp_q[n].op, exp_q[n].pl);
      end
    end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL rnd_err got %0d want 0", err_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sync();
    test_timeout();
    test_backpressure();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
